icap_arbiter: RTL and testbench

- Shares the single ICAPE3 configuration port between P_NREQ requesters, e.g. the multiboot/IPROG sequencer, a readback/scrub engine and a partial-reconfig streamer.
- Provides request/grant ownership with round-robin fairness and registered muxing of CSIB/RDWRB/I toward the primitive.
- Inserts a CSIB-high guard gap on every ownership change and force-releases an owner that holds the port too long.
- Sits between the requester controllers and the ICAPE3 instance, in the same clock domain as the ICAP.

---
 rtl/icap_pkg.sv | 39 +++
 rtl/icap_arbiter_if.sv | 36 +++
 rtl/icap_arbiter_rr_pick.sv | 30 +++
 rtl/icap_arbiter.sv | 138 +++++++++++++
 tb/tb_icap_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icap_pkg.sv
// icap_pkg: FSM encodings and ICAPE3 command words shared by the
// arbiter, its requesters and benches.
package icap_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_OWN     = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   typedef logic [31:0] icap_word_t;

   localparam icap_word_t CMD_DUMMY    = 32'hFFFFFFFF;
   localparam icap_word_t CMD_SYNC     = 32'hAA995566;
   localparam icap_word_t CMD_NOOP     = 32'h20000000;
   localparam icap_word_t CMD_WRWBSTAR = 32'h30020001;
   localparam icap_word_t CMD_WRCMD    = 32'h30008001;
   localparam icap_word_t CMD_IPROG    = 32'h0000000F;

   // ICAPE3 wants each byte bit-reversed; these are the wire forms.
   localparam icap_word_t SW_DUMMY    = 32'hFFFFFFFF;
   localparam icap_word_t SW_SYNC     = 32'h5599AA66;
   localparam icap_word_t SW_NOOP     = 32'h04000000;
   localparam icap_word_t SW_WRWBSTAR = 32'h0C400080;
   localparam icap_word_t SW_WRCMD    = 32'h0C000180;
   localparam icap_word_t SW_IPROG    = 32'h000000F0;

   function automatic icap_word_t bitswap(icap_word_t w);
      icap_word_t r;
      for (int b = 0; b < 4; b++)
         for (int i = 0; i < 8; i++)
            r[8*b+i] = w[8*b+7-i];
      return r;
   endfunction

   function automatic int idx_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icap_arbiter_if.sv
// icap_arbiter_if: requester- and ICAPE3-side signals of the arbiter.
// slave is the arbiter's view, master the surrounding logic's.
interface icap_arbiter_if #(
   parameter int P_NREQ = 2
) ();

   logic [P_NREQ-1:0]    I_req;
   logic [P_NREQ-1:0]    O_gnt;
   logic [P_NREQ-1:0]    I_csib;
   logic [P_NREQ-1:0]    I_rdwrb;
   logic [32*P_NREQ-1:0] I_din;
   logic [31:0]          O_dout;
   logic                 O_avail;
   logic                 O_timeout;
   logic [2:0]           O_owner;
   logic                 O_icap_csib;
   logic                 O_icap_rdwrb;
   logic [31:0]          O_icap_i;
   logic [31:0]          I_icap_o;
   logic                 I_icap_avail;

   modport slave (
      input  I_req, I_csib, I_rdwrb, I_din,
      input  I_icap_o, I_icap_avail,
      output O_gnt, O_dout, O_avail, O_timeout, O_owner,
      output O_icap_csib, O_icap_rdwrb, O_icap_i
   );

   modport master (
      output I_req, I_csib, I_rdwrb, I_din,
      output I_icap_o, I_icap_avail,
      input  O_gnt, O_dout, O_avail, O_timeout, O_owner,
      input  O_icap_csib, O_icap_rdwrb, O_icap_i
   );

endinterface

// File: rtl/icap_arbiter_rr_pick.sv
// rr_pick: first set bit of req at or after ptr, wrapping modulo
// P_NREQ. Purely combinational.
module rr_pick
   import icap_pkg::*;
#(
   parameter  int P_NREQ = 2,
   localparam int IW     = idx_w(P_NREQ)
) (
   input  logic [P_NREQ-1:0] req,
   input  logic [IW-1:0]     ptr,
   output logic              valid,
   output logic [IW-1:0]     index
);

   always_comb begin
      logic [IW-1:0] j;
      valid = 1'b0;
      index = '0;
      j     = '0;
      // Walk downward so the nearest candidate is written last.
      for (int i = P_NREQ - 1; i >= 0; i--) begin
         j = IW'((int'(ptr) + i) % P_NREQ);
         if (req[j]) begin
            valid = 1'b1;
            index = j;
         end
      end
   end

endmodule

// File: rtl/icap_arbiter.sv
// icap_arbiter: round-robin ownership of the single ICAPE3 port,
// with a CSIB-high guard gap on hand-over and an ownership watchdog.
module icap_arbiter
   import icap_pkg::*;
#(
   parameter int          P_NREQ    = 2,
   parameter int          P_GAP     = 2,
   parameter logic [15:0] P_TIMEOUT = 16'd65535
) (
   input logic           I_clk,
   input logic           I_rst_n,
   icap_arbiter_if.slave bus
);

   localparam int IW = idx_w(P_NREQ);
   localparam int GW = $clog2(P_GAP + 1);

   logic [1:0]        state;
   logic [IW-1:0]     sel;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     sel_next;
   logic [IW-1:0]     pick_idx;
   logic              pick_valid;
   logic [P_NREQ-1:0] mask;
   logic [P_NREQ-1:0] cand;
   logic [P_NREQ-1:0] sel_hot;
   logic [15:0]       tcnt;
   logic [15:0]       tcnt_inc;
   logic              timeout_hit;
   logic [GW-1:0]     gap;
   logic              own_req;
   logic              own_csib;
   logic              own_rdwrb;
   logic [31:0]       own_din;

   assign cand = bus.I_req & ~mask;

   rr_pick #(
      .P_NREQ(P_NREQ)
   ) u_pick (
      .req  (cand),
      .ptr  (ptr),
      .valid(pick_valid),
      .index(pick_idx)
   );

   assign sel_hot  = P_NREQ'(1) << sel;
   assign sel_next = (sel == IW'(P_NREQ - 1)) ? '0 : sel + 1'b1;
   assign tcnt_inc = (tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1;

   assign timeout_hit = (P_TIMEOUT != 16'd0) &&
                        (tcnt_inc == P_TIMEOUT);

   assign own_req   = bus.I_req[sel];
   assign own_csib  = bus.I_csib[sel];
   assign own_rdwrb = bus.I_rdwrb[sel];

   always_comb begin
      own_din = '0;
      for (int k = 0; k < P_NREQ; k++)
         if (sel == IW'(k))
            own_din = bus.I_din[32*k +: 32];
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state            <= ST_IDLE;
         sel              <= '0;
         ptr              <= '0;
         mask             <= '0;
         tcnt             <= '0;
         gap              <= '0;
         bus.O_gnt        <= '0;
         bus.O_icap_csib  <= 1'b1;
         bus.O_icap_rdwrb <= 1'b1;
         bus.O_icap_i     <= '0;
         bus.O_dout       <= '0;
         bus.O_avail      <= 1'b0;
         bus.O_timeout    <= 1'b0;
         bus.O_owner      <= '0;
      end else begin
         bus.O_dout    <= bus.I_icap_o;
         bus.O_avail   <= bus.I_icap_avail;
         bus.O_timeout <= 1'b0;
         mask          <= mask & bus.I_req;
         case (state)
            ST_IDLE: begin
               if (pick_valid && bus.I_icap_avail) begin
                  sel   <= pick_idx;
                  state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               bus.O_gnt   <= sel_hot;
               bus.O_owner <= 3'(sel);
               tcnt        <= '0;
               state       <= ST_OWN;
            end
            ST_OWN: begin
               tcnt <= tcnt_inc;
               if (!own_req || timeout_hit) begin
                  bus.O_gnt        <= '0;
                  bus.O_icap_csib  <= 1'b1;
                  bus.O_icap_rdwrb <= 1'b1;
                  bus.O_icap_i     <= '0;
                  ptr              <= sel_next;
                  gap              <= '0;
                  state            <= ST_RELEASE;
                  // Still requesting here means the watchdog fired.
                  if (own_req) begin
                     bus.O_timeout <= 1'b1;
                     mask <= (mask & bus.I_req) | sel_hot;
                  end
               end else begin
                  bus.O_icap_csib  <= own_csib;
                  bus.O_icap_rdwrb <= own_rdwrb;
                  bus.O_icap_i     <= own_din;
               end
            end
            ST_RELEASE: begin
               if (gap == GW'(P_GAP - 1))
                  state <= ST_IDLE;
               else
                  gap <= gap + 1'b1;
            end
            default: begin
               bus.O_gnt        <= '0;
               bus.O_icap_csib  <= 1'b1;
               bus.O_icap_rdwrb <= 1'b1;
               bus.O_icap_i     <= '0;
               gap              <= '0;
               state            <= ST_RELEASE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icap_arbiter.sv
// tb_icap_arbiter: vector table, corner sequences and random traffic
// against a timestamp-based ownership model.
module tb_icap_arbiter;
   import icap_pkg::*;

   localparam int          N   = 2;
   localparam int          GAP = 2;
   localparam logic [15:0] TMO = 16'd16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   icap_arbiter_if #(.P_NREQ(N)) bus ();

   icap_arbiter #(
      .P_NREQ   (N),
      .P_GAP    (GAP),
      .P_TIMEOUT(TMO)
   ) dut (
      .I_clk  (clk),
      .I_rst_n(rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // model: owner/candidate indices and cycle timestamps
   int t, m_owner, m_chosen, m_own, m_idle_from, m_ptr;
   bit m_mask [N];
   logic [N-1:0] e_gnt;
   logic         e_csib, e_rdwrb, e_avail, e_to;
   logic [31:0]  e_i, e_dout;
   logic [2:0]   e_owner;

   typedef struct {
      logic [1:0]  req;
      logic        c0;
      logic        r0;
      logic [31:0] d0;
      logic        av;
      logic [1:0]  g;
      logic        c;
      logic        r;
      logic [31:0] i;
   } vec_t;

   vec_t tbl [21];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      t           = 0;
      m_owner     = -1;
      m_chosen    = -1;
      m_own       = 0;
      m_idle_from = 0;
      m_ptr       = 0;
      for (int j = 0; j < N; j++) m_mask[j] = 1'b0;
      e_gnt   = '0;
      e_csib  = 1'b1;
      e_rdwrb = 1'b1;
      e_i     = '0;
      e_dout  = '0;
      e_avail = 1'b0;
      e_to    = 1'b0;
      e_owner = '0;
   endtask

   task automatic model_edge();
      bit nm [N];
      int k;
      t++;
      e_dout  = bus.I_icap_o;
      e_avail = bus.I_icap_avail;
      e_to    = 1'b0;
      for (int j = 0; j < N; j++) nm[j] = m_mask[j] && bus.I_req[j];
      if (m_chosen >= 0) begin
         m_owner  = m_chosen;
         m_chosen = -1;
         e_gnt    = '0;
         e_gnt[m_owner] = 1'b1;
         e_owner  = 3'(m_owner);
         m_own    = 0;
      end else if (m_owner >= 0) begin
         m_own++;
         k = m_owner;
         if (!bus.I_req[k] || m_own == int'(TMO)) begin
            if (bus.I_req[k]) begin
               e_to  = 1'b1;
               nm[k] = 1'b1;
            end
            e_gnt       = '0;
            e_csib      = 1'b1;
            e_rdwrb     = 1'b1;
            e_i         = '0;
            m_ptr       = (k + 1) % N;
            m_owner     = -1;
            m_idle_from = t + GAP + 1;
         end else begin
            e_csib  = bus.I_csib[k];
            e_rdwrb = bus.I_rdwrb[k];
            e_i     = bus.I_din[32*k +: 32];
         end
      end else if (t >= m_idle_from && bus.I_icap_avail) begin
         for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (bus.I_req[k] && !m_mask[k]) begin
               m_chosen = k;
               break;
            end
         end
      end
      m_mask = nm;
   endtask

   task automatic step(input logic [1:0] req, input logic [1:0] cs,
                       input logic [1:0] rw, input logic [63:0] din,
                       input logic av);
      bus.I_req        = req;
      bus.I_csib       = cs;
      bus.I_rdwrb      = rw;
      bus.I_din        = din;
      bus.I_icap_avail = av;
      bus.I_icap_o     = $urandom;
      @(posedge clk);
      model_edge();
      #1;
      chk("m_gnt", 32'(bus.O_gnt), 32'(e_gnt));
      chk("m_csib", 32'(bus.O_icap_csib), 32'(e_csib));
      chk("m_rdwrb", 32'(bus.O_icap_rdwrb), 32'(e_rdwrb));
      chk("m_icap_i", bus.O_icap_i, e_i);
      chk("m_dout", bus.O_dout, e_dout);
      chk("m_avail", 32'(bus.O_avail), 32'(e_avail));
      chk("m_timeout", 32'(bus.O_timeout), 32'(e_to));
      chk("m_owner", 32'(bus.O_owner), 32'(e_owner));
   endtask

   task automatic wait_gnt(input logic [1:0] req, output int n);
      n = 0;
      do begin
         step(req, 2'b11, 2'b11, 64'h0, 1'b1);
         n++;
      end while (bus.O_gnt == '0 && n < 20);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"}, 32'(bus.O_gnt), 32'h0);
      chk({tag, "_csib"}, 32'(bus.O_icap_csib), 32'h1);
      chk({tag, "_rdwrb"}, 32'(bus.O_icap_rdwrb), 32'h1);
      chk({tag, "_icap_i"}, bus.O_icap_i, 32'h0);
      chk({tag, "_dout"}, bus.O_dout, 32'h0);
      chk({tag, "_avail"}, 32'(bus.O_avail), 32'h0);
      chk({tag, "_timeout"}, 32'(bus.O_timeout), 32'h0);
      chk({tag, "_owner"}, 32'(bus.O_owner), 32'h0);
   endtask

   initial begin
      int n, bad;
      bit found;
      logic [1:0] rq, cs, rw;

      tbl[0]  = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[1]  = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b01, 1'b1, 1'b1, 32'h0};
      tbl[2]  = '{2'b01, 1'b0, 1'b0, SW_DUMMY, 1'b1,
                  2'b01, 1'b0, 1'b0, SW_DUMMY};
      tbl[3]  = '{2'b01, 1'b0, 1'b0, SW_SYNC, 1'b1,
                  2'b01, 1'b0, 1'b0, SW_SYNC};
      tbl[4]  = '{2'b01, 1'b0, 1'b1, SW_NOOP, 1'b1,
                  2'b01, 1'b0, 1'b1, SW_NOOP};
      tbl[5]  = '{2'b00, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[6]  = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[7]  = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[8]  = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[9]  = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b01, 1'b1, 1'b1, 32'h0};
      tbl[10] = '{2'b01, 1'b0, 1'b0, CMD_SYNC, 1'b1,
                  2'b01, 1'b0, 1'b0, CMD_SYNC};
      tbl[11] = '{2'b00, 1'b0, 1'b0, CMD_SYNC, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[12] = '{2'b00, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[13] = '{2'b00, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[14] = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b0,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[15] = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b0,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[16] = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[17] = '{2'b01, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b01, 1'b1, 1'b1, 32'h0};
      tbl[18] = '{2'b00, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[19] = '{2'b00, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};
      tbl[20] = '{2'b00, 1'b1, 1'b1, 32'h0, 1'b1,
                  2'b00, 1'b1, 1'b1, 32'h0};

      bus.I_req        = '0;
      bus.I_csib       = '1;
      bus.I_rdwrb      = '1;
      bus.I_din        = '0;
      bus.I_icap_o     = 32'h1234ABCD;
      bus.I_icap_avail = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("por");
      rst_n = 1'b1;

      // Requester 1 sits with CSIB/RDWRB low and a marker word so
      // any leak of non-owner inputs shows up on the ICAP side.
      for (int v = 0; v < 21; v++) begin
         step(tbl[v].req, {1'b0, tbl[v].c0}, {1'b0, tbl[v].r0},
              {32'h12345678, tbl[v].d0}, tbl[v].av);
         chk($sformatf("tbl%0d_gnt", v), 32'(bus.O_gnt),
             32'(tbl[v].g));
         chk($sformatf("tbl%0d_csib", v), 32'(bus.O_icap_csib),
             32'(tbl[v].c));
         chk($sformatf("tbl%0d_rdwrb", v), 32'(bus.O_icap_rdwrb),
             32'(tbl[v].r));
         chk($sformatf("tbl%0d_icap_i", v), bus.O_icap_i,
             tbl[v].i);
      end

      wait_gnt(2'b10, n);
      chk("rst_pre_gnt", 32'(bus.O_gnt), 32'h2);
      repeat (2) step(2'b10, 2'b01, 2'b01,
                      {32'hCAFEF00D, 32'h0}, 1'b1);
      chk("rst_pre_csib", 32'(bus.O_icap_csib), 32'h0);
      chk("rst_pre_i", bus.O_icap_i, 32'hCAFEF00D);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      model_reset();
      bus.I_req = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      wait_gnt(2'b11, n);
      chk("rr_first_gnt", 32'(bus.O_gnt), 32'h1);
      chk("rr_latency", 32'(n), 32'd2);
      wait_gnt(2'b10, n);
      chk("rr_second_gnt", 32'(bus.O_gnt), 32'h2);
      chk("rr_second_owner", 32'(bus.O_owner), 32'h1);
      step(2'b01, 2'b11, 2'b11, 64'h0, 1'b1);
      wait_gnt(2'b11, n);
      chk("rr_wrap_gnt", 32'(bus.O_gnt), 32'h1);
      repeat (4) step(2'b00, 2'b11, 2'b11, 64'h0, 1'b1);

      wait_gnt(2'b01, n);
      chk("to_gnt", 32'(bus.O_gnt), 32'h1);
      n     = 0;
      found = 1'b0;
      for (int c = 1; c <= 40 && !found; c++) begin
         step(2'b01, 2'b11, 2'b11, 64'h0, 1'b1);
         if (bus.O_timeout) begin
            found = 1'b1;
            n     = c;
         end
      end
      chk("to_cycles", 32'(n), 32'd16);
      chk("to_gnt_low", 32'(bus.O_gnt), 32'h0);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         step(2'b01, 2'b11, 2'b11, 64'h0, 1'b1);
         if (bus.O_gnt != '0) bad++;
      end
      chk("to_no_regrant", 32'(bad), 32'd0);
      step(2'b00, 2'b11, 2'b11, 64'h0, 1'b1);
      wait_gnt(2'b01, n);
      chk("to_regrant", 32'(bus.O_gnt), 32'h1);
      chk("to_regrant_lat", 32'(n), 32'd2);
      repeat (4) step(2'b00, 2'b11, 2'b11, 64'h0, 1'b1);

      rq = '0;
      for (int c = 0; c < 800; c++) begin
         for (int j = 0; j < N; j++) begin
            if (rq[j]) begin
               if ($urandom_range(0, 5) == 0) rq[j] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               rq[j] = 1'b1;
            end
            cs[j] = (rq[j] && bus.O_gnt[j]) ? 1'($urandom) : 1'b1;
            rw[j] = (rq[j] && bus.O_gnt[j]) ? 1'($urandom) : 1'b1;
         end
         step(rq, cs, rw, {$urandom, $urandom},
              $urandom_range(0, 7) != 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
